// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 width codes, FSM state
// encoding and request legality helpers.
package lsu_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    RESP
  } lsu_state_t;

  // Halfword accesses need addr[0] clear, word accesses need addr[1:0] clear.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
    logic result;
    case (funct3)
      F3_H, F3_HU: result = lane[0];
      F3_W:        result = |lane;
      default:     result = 1'b0;
    endcase
    return result;
  endfunction

  // Unsigned widths exist only for loads; 011/110/111 are never legal.
  function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
    logic result;
    case (funct3)
      F3_B, F3_H, F3_W: result = 1'b0;
      F3_BU, F3_HU:     result = we;
      default:          result = 1'b1;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract with sign/zero extension, and
// store merge of a byte/halfword into an existing word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        lane,
  input  logic [WORD_W-1:0] word,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] ext_data,
  output logic [WORD_W-1:0] merge_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    ext_data = '0;
    case (funct3)
      F3_B:    ext_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    ext_data = {{16{half_sel[15]}}, half_sel};
      F3_W:    ext_data = word;
      F3_BU:   ext_data = {24'h000000, byte_sel};
      F3_HU:   ext_data = {16'h0000, half_sel};
      default: ext_data = '0;
    endcase
  end

  // Full-word stores pass wdata straight through.
  always_comb begin
    merge_data = word;
    case (funct3)
      F3_B: merge_data[{lane, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (lane[1]) merge_data[31:16] = wdata[15:0];
        else         merge_data[15:0]  = wdata[15:0];
      end
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_rmw_ctrl.sv
// Load/store unit in front of a word-only data memory: sub-word loads,
// read-modify-write for SB/SH, alignment faults and a valid/ready stall.
// Optional one-entry last-word cache under LSU_LAST_WORD_CACHE_EN.
module lsu_rmw_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_fault,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata
);

  lsu_state_t        state;
  logic              op_we;
  logic [2:0]        op_funct3;
  logic [1:0]        op_lane;
  logic [DATA_W-1:0] op_wdata;

  logic              req_fault;
  logic [ADDR_W-1:0] req_word_addr;
  logic              cache_hit;

  logic [2:0]        al_funct3;
  logic [1:0]        al_lane;
  logic [DATA_W-1:0] al_word;
  logic [DATA_W-1:0] al_wdata;
  logic [DATA_W-1:0] al_ext;
  logic [DATA_W-1:0] al_merge;

  assign req_fault     = is_illegal(req_we, req_funct3) || is_misaligned(req_funct3, req_addr[1:0]);
  assign req_word_addr = {req_addr[ADDR_W-1:2], 2'b00};

`ifdef LSU_LAST_WORD_CACHE_EN
  logic              cache_valid;
  logic [ADDR_W-3:0] cache_tag;
  logic [DATA_W-1:0] cache_data;

  assign cache_hit = cache_valid && (cache_tag == req_addr[ADDR_W-1:2]);
  assign al_word   = (state == IDLE) ? cache_data : dmem_rdata;
`else
  assign cache_hit = 1'b0;
  assign al_word   = dmem_rdata;
`endif

  // One aligner serves the request in IDLE (cache merge) and the latched op later.
  assign al_funct3 = (state == IDLE) ? req_funct3    : op_funct3;
  assign al_lane   = (state == IDLE) ? req_addr[1:0] : op_lane;
  assign al_wdata  = (state == IDLE) ? req_wdata     : op_wdata;

  lsu_align u_align (
    .funct3     (al_funct3),
    .lane       (al_lane),
    .word       (al_word),
    .wdata      (al_wdata),
    .ext_data   (al_ext),
    .merge_data (al_merge)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_fault  <= 1'b0;
      rsp_rdata  <= '0;
      dmem_read  <= 1'b0;
      dmem_write <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      op_we      <= 1'b0;
      op_funct3  <= '0;
      op_lane    <= '0;
      op_wdata   <= '0;
`ifdef LSU_LAST_WORD_CACHE_EN
      cache_valid <= 1'b0;
      cache_tag   <= '0;
      cache_data  <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_we     <= req_we;
            op_funct3 <= req_funct3;
            op_lane   <= req_addr[1:0];
            op_wdata  <= req_wdata;
            req_ready <= 1'b0;
            if (req_fault) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_fault <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              dmem_addr <= req_word_addr;
              if (!req_we) begin
                state     <= LOAD;
                dmem_read <= 1'b1;
              end else if (req_funct3 == F3_W || cache_hit) begin
                // SW, or SB/SH merged against the cached copy of the word
                state      <= WRITE;
                dmem_write <= 1'b1;
                dmem_wdata <= (req_funct3 == F3_W) ? req_wdata : al_merge;
`ifdef LSU_LAST_WORD_CACHE_EN
                cache_valid <= 1'b1;
                cache_tag   <= req_addr[ADDR_W-1:2];
                cache_data  <= (req_funct3 == F3_W) ? req_wdata : al_merge;
`endif
              end else begin
                state     <= RMW_RD;
                dmem_read <= 1'b1;
              end
            end
          end
        end
        LOAD: begin
          dmem_read <= 1'b0;
          rsp_rdata <= op_we ? '0 : al_ext;
          rsp_valid <= 1'b1;
          state     <= RESP;
`ifdef LSU_LAST_WORD_CACHE_EN
          cache_valid <= 1'b1;
          cache_tag   <= dmem_addr[ADDR_W-1:2];
          cache_data  <= dmem_rdata;
`endif
        end
        RMW_RD: begin
          // Old word is consumed on the same edge it is read.
          dmem_read  <= 1'b0;
          dmem_write <= 1'b1;
          dmem_wdata <= al_merge;
          state      <= WRITE;
`ifdef LSU_LAST_WORD_CACHE_EN
          cache_valid <= 1'b1;
          cache_tag   <= dmem_addr[ADDR_W-1:2];
          cache_data  <= al_merge;
`endif
        end
        WRITE: begin
          dmem_write <= 1'b0;
          rsp_valid  <= 1'b1;
          rsp_rdata  <= '0;
          state      <= RESP;
        end
        RESP: begin
          rsp_fault <= 1'b0;
          rsp_rdata <= '0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          dmem_read  <= 1'b0;
          dmem_write <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_rmw_ctrl.sv
// Directed bench for lsu_rmw_ctrl with a word memory model; expectations
// adapt to LSU_LAST_WORD_CACHE_EN when the same macro is set for the build.
module tb_lsu_rmw_ctrl;

`ifdef LSU_LAST_WORD_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;

  logic [31:0] mem [64];

  int total;
  int bad;

  lsu_rmw_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_fault  (rsp_fault),
    .dmem_read  (dmem_read),
    .dmem_write (dmem_write),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory resets with the block to a known image.
  assign dmem_rdata = mem[dmem_addr[7:2]];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[16] <= 32'h8899AABB;
    end else if (dmem_write) begin
      mem[dmem_addr[7:2]] <= dmem_wdata;
    end
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_fault;
    int          lat;
    int          reads;
    int          writes;
    logic        hit;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rdata,
                              input logic exp_fault, input int lat, input int reads,
                              input int writes, input logic hit, input logic [31:0] exp_wd);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata;
    v.exp_fault = exp_fault; v.lat = lat; v.reads = reads; v.writes = writes;
    v.hit = hit; v.exp_wd = exp_wd;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input int idx);
    int cyc, reads, writes, lat_exp, rd_exp;
    bit got;
    logic [31:0] wd, rdata, waddr;
    logic flt;
    cyc = 0;
    while (!req_ready && cyc < 20) begin @(negedge clk); cyc++; end
    check("ready", idx, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk);
    #1;
    // Noise on the request bus must be ignored once accepted.
    req_valid = 1'b0; req_we = ~v.we; req_funct3 = 3'b011; req_addr = ~v.addr; req_wdata = 32'h0;
    waddr = {v.addr[31:2], 2'b00};
    got = 1'b0; cyc = 0; reads = 0; writes = 0; wd = 32'h0; rdata = 32'h0; flt = 1'b0;
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      check("rd_wr_excl", idx, 32'(dmem_read & dmem_write), 32'd0);
      if (dmem_read || dmem_write) check("dmem_addr", idx, dmem_addr, waddr);
      if (dmem_read) reads++;
      if (dmem_write) begin writes++; wd = dmem_wdata; end
      if (rsp_valid) begin got = 1'b1; rdata = rsp_rdata; flt = rsp_fault; end
    end
    lat_exp = (v.hit && CACHE) ? v.lat - 1 : v.lat;
    rd_exp  = (v.hit && CACHE) ? v.reads - 1 : v.reads;
    check("rsp_seen", idx, 32'(got), 32'd1);
    check("latency", idx, 32'(cyc), 32'(lat_exp));
    check("rsp_rdata", idx, rdata, v.exp_rdata);
    check("rsp_fault", idx, 32'(flt), 32'(v.exp_fault));
    check("reads", idx, 32'(reads), 32'(rd_exp));
    check("writes", idx, 32'(writes), 32'(v.writes));
    if (v.writes > 0) check("wdata", idx, wd, v.exp_wd);
    @(negedge clk);
    check("rsp_pulse", idx, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit seen;
    vec_t v;
    total = 0; bad = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;

    //         we  f3      addr    wdata         rdata         flt lat rd wr hit wdata
    vecs.push_back(mk(0, 3'b000, 32'h41, 32'h0,        32'hFFFFFFAA, 0, 2, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 3'b100, 32'h41, 32'h0,        32'h000000AA, 0, 2, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 3'b101, 32'h42, 32'h0,        32'h00008899, 0, 2, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 3'b001, 32'h42, 32'h0,        32'hFFFF8899, 0, 2, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 3'b010, 32'h40, 32'h0,        32'h8899AABB, 0, 2, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 3'b000, 32'h42, 32'h0000005C, 32'h0,        0, 3, 1, 1, 1, 32'h885CAABB));
    vecs.push_back(mk(0, 3'b010, 32'h40, 32'h0,        32'h885CAABB, 0, 2, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 3'b010, 32'h44, 32'hDEADBEEF, 32'h0,        0, 2, 0, 1, 0, 32'hDEADBEEF));
    vecs.push_back(mk(0, 3'b010, 32'h44, 32'h0,        32'hDEADBEEF, 0, 2, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 3'b010, 32'h42, 32'h0,        32'h0,        1, 1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 3'b001, 32'h43, 32'h1234,     32'h0,        1, 1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 3'b011, 32'h40, 32'h0,        32'h0,        1, 1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 3'b100, 32'h40, 32'h12,       32'h0,        1, 1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 3'b001, 32'h46, 32'h00001234, 32'h0,        0, 3, 1, 1, 1, 32'h1234BEEF));
    vecs.push_back(mk(0, 3'b000, 32'h47, 32'h0,        32'h00000012, 0, 2, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 3'b001, 32'h44, 32'h0,        32'hFFFFBEEF, 0, 2, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 3'b100, 32'h44, 32'h0,        32'h000000EF, 0, 2, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 3'b101, 32'h46, 32'h0,        32'h00001234, 0, 2, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 3'b000, 32'h50, 32'hABCDEFFF, 32'h0,        0, 3, 1, 1, 0, 32'h000000FF));
    vecs.push_back(mk(0, 3'b000, 32'h50, 32'h0,        32'hFFFFFFFF, 0, 2, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 3'b010, 32'h80, 32'h11223344, 32'h0,        0, 2, 0, 1, 0, 32'h11223344));
    vecs.push_back(mk(1, 3'b001, 32'h82, 32'h5555BEEF, 32'h0,        0, 3, 1, 1, 1, 32'hBEEF3344));
    vecs.push_back(mk(0, 3'b010, 32'h80, 32'h0,        32'hBEEF3344, 0, 2, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 3'b101, 32'h41, 32'h0,        32'h0,        1, 1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 3'b110, 32'h40, 32'h0,        32'h0,        1, 1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 3'b111, 32'h40, 32'h0,        32'h0,        1, 1, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 3'b000, 32'h43, 32'h00000011, 32'h0,        0, 3, 1, 1, 0, 32'h115CAABB));
    vecs.push_back(mk(0, 3'b010, 32'h40, 32'h0,        32'h115CAABB, 0, 2, 1, 0, 0, 32'h0));

    // Reset values, sampled while reset is held and just after release.
    repeat (2) @(negedge clk);
    check("rst_ready", 0, 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 0, 32'(rsp_valid), 32'd0);
    check("rst_rsp_fault", 0, 32'(rsp_fault), 32'd0);
    check("rst_rsp_rdata", 0, rsp_rdata, 32'h0);
    check("rst_dmem_read", 0, 32'(dmem_read), 32'd0);
    check("rst_dmem_write", 0, 32'(dmem_write), 32'd0);
    check("rst_dmem_addr", 0, dmem_addr, 32'h0);
    check("rst_dmem_wdata", 0, dmem_wdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 0, 32'(req_ready), 32'd1);

    foreach (vecs[i]) run_op(vecs[i], i);

    // Reset asserted while an SB is in WRITE.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h60; req_wdata = 32'h55;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!dmem_write && cyc < 10);
    check("mr_write_seen", 0, 32'(dmem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mr_write_drop", 0, 32'(dmem_write), 32'd0);
    check("mr_ready", 0, 32'(req_ready), 32'd1);
    check("mr_rsp_valid", 0, 32'(rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
    check("mr_no_rsp", 0, 32'(seen), 32'd0);
    check("mr_mem_untouched", 0, mem[24], 32'h0);

    // Same word after reset: any cached copy must be gone, so full RMW.
    v = mk(1, 3'b000, 32'h61, 32'h00000077, 32'h0, 0, 3, 1, 1, 0, 32'h00007700);
    run_op(v, 100);
    v = mk(0, 3'b001, 32'h60, 32'h0, 32'h00007700, 0, 2, 1, 0, 0, 32'h0);
    run_op(v, 101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
